// File: rtl/led_flash_array.sv
// Multi-channel LED flash stretcher: each channel turns a trigger into a fixed-length
// flash, optionally held on, followed by a forced-dark gap before the next flash.

module led_flash_chan #(
   parameter int MXCNT  = 19,
   parameter int GAPW   = 17,
   parameter int RETRIG = 0,
   parameter int INV    = 0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic trigger,
   input  logic hold,
   output logic led,
   output logic busy
);

   // One-hot so that a corrupted state register is detectable and recovers to IDLE.
   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      FLASH = 4'b0010,
      HWAIT = 4'b0100,
      GAP   = 4'b1000
   } state_t;

   localparam logic           LED_OFF   = (INV != 0);
   localparam logic           RETRIG_EN = (RETRIG != 0);
   localparam logic [MXCNT:0] CNT_ONE   = (MXCNT + 1)'(1);
   localparam logic [GAPW:0]  GCNT_ONE  = (GAPW + 1)'(1);

   logic           trig_ff = 1'b0;
   logic           hold_ff = 1'b0;
   state_t         state   = IDLE;
   state_t         state_nxt;
   logic [MXCNT:0] cnt     = '0;
   logic [GAPW:0]  gcnt    = '0;
   logic           pend    = 1'b0;
   logic           led_q   = LED_OFF;
   logic           busy_q  = 1'b0;
   logic           led_d;
   logic           busy_d;

   // A trigger also counts as a hold so a single pulse never falls straight through HWAIT.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         trig_ff <= 1'b0;
         hold_ff <= 1'b0;
      end else begin
         trig_ff <= trigger;
         hold_ff <= hold | trigger;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: state_nxt is defaulted before the case so no path can infer a latch.
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = trig_ff ? FLASH : IDLE;
         FLASH:   state_nxt = cnt[MXCNT] ? HWAIT : FLASH;
         HWAIT:   state_nxt = hold_ff ? HWAIT : GAP;
         GAP: begin
            if (gcnt[GAPW]) begin
               state_nxt = (pend || trig_ff) ? FLASH : IDLE;
            end else begin
               state_nxt = GAP;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Counters idle at zero outside their own state, so entry needs no explicit clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         gcnt <= '0;
         pend <= 1'b0;
      end else begin
         if ((state != FLASH) || (RETRIG_EN && trig_ff)) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_ONE;
         end

         if (state != GAP) begin
            gcnt <= '0;
         end else begin
            gcnt <= gcnt + GCNT_ONE;
         end

         if ((state != GAP) || gcnt[GAPW]) begin
            pend <= 1'b0;
         end else if (trig_ff) begin
            pend <= 1'b1;
         end
      end
   end

   always_comb begin
      led_d  = ((state == FLASH) || (state == HWAIT)) ^ LED_OFF;
      busy_d = (state != IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         led_q  <= LED_OFF;
         busy_q <= 1'b0;
      end else begin
         led_q  <= led_d;
         busy_q <= busy_d;
      end
   end

   assign led  = led_q;
   assign busy = busy_q;

endmodule

module led_flash_array #(
   parameter int NCH    = 8,
   parameter int MXCNT  = 19,
   parameter int GAPW   = 17,
   parameter int RETRIG = 0,
   parameter int INV    = 0
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic [NCH-1:0] trigger,
   input  logic [NCH-1:0] hold,
   output logic [NCH-1:0] led,
   output logic [NCH-1:0] busy
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      led_flash_chan #(
         .MXCNT  (MXCNT),
         .GAPW   (GAPW),
         .RETRIG (RETRIG),
         .INV    (INV)
      ) u_ch (
         .clock   (clock),
         .reset_n (reset_n),
         .trigger (trigger[i]),
         .hold    (hold[i]),
         .led     (led[i]),
         .busy    (busy[i])
      );
   end

endmodule

// File: tb/tb_led_flash_array.sv
// Scoreboard bench for led_flash_array: three small instances (plain, retrigger, inverted)
// driven by directed per-cycle vectors; cycle c means "after clock edge Tc".

module tb_led_flash_array;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] trig_a = '0, hold_a = '0;
   logic [3:0] trig_r = '0, hold_r = '0;
   logic [3:0] trig_i = '0, hold_i = '0;
   logic [3:0] led_a, busy_a, led_r, busy_r, led_i, busy_i;

   typedef struct {
      logic       rst_n;
      logic [3:0] trig_a, hold_a, trig_r, hold_r, trig_i, hold_i;
   } stim_t;

   typedef struct {
      string      tag;
      int         cyc;
      logic [3:0] led_a, busy_a, led_r, busy_r, led_i, busy_i;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   led_flash_array #(.NCH(4), .MXCNT(2), .GAPW(1), .RETRIG(0), .INV(0)) dut_a (
      .clock(clk), .reset_n(rst_n), .trigger(trig_a), .hold(hold_a), .led(led_a), .busy(busy_a));

   led_flash_array #(.NCH(4), .MXCNT(2), .GAPW(1), .RETRIG(1), .INV(0)) dut_r (
      .clock(clk), .reset_n(rst_n), .trigger(trig_r), .hold(hold_r), .led(led_r), .busy(busy_r));

   led_flash_array #(.NCH(4), .MXCNT(2), .GAPW(1), .RETRIG(0), .INV(1)) dut_i (
      .clock(clk), .reset_n(rst_n), .trigger(trig_i), .hold(hold_i), .led(led_i), .busy(busy_i));

   function automatic logic w(input int c, input int lo, input int hi);
      return (c >= lo) && (c <= hi);
   endfunction

   function automatic stim_t idle_stim();
      stim_t s;
      s.rst_n  = 1'b1;
      s.trig_a = '0; s.hold_a = '0;
      s.trig_r = '0; s.hold_r = '0;
      s.trig_i = '0; s.hold_i = '0;
      return s;
   endfunction

   function automatic exp_t idle_exp(input string tag, input int c);
      exp_t e;
      e.tag    = tag;
      e.cyc    = c;
      e.led_a  = 4'h0; e.busy_a = 4'h0;
      e.led_r  = 4'h0; e.busy_r = 4'h0;
      e.led_i  = 4'hF; e.busy_i = 4'h0;
      return e;
   endfunction

   // Drive one cycle of stimulus just after the edge and queue what should be visible this cycle.
   task automatic apply(input stim_t s, input exp_t e);
      @(posedge clk);
      #1;
      rst_n  = s.rst_n;
      trig_a = s.trig_a; hold_a = s.hold_a;
      trig_r = s.trig_r; hold_r = s.hold_r;
      trig_i = s.trig_i; hold_i = s.hold_i;
      sb.push_back(e);
   endtask

   task automatic check(input string tag, input int cyc, input string who,
                        input logic [7:0] got, input logic [7:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s cyc %0d %s led/busy got %b/%b expected %b/%b",
                  tag, cyc, who, got[7:4], got[3:0], want[7:4], want[3:0]);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, e.cyc, "dut_a", {led_a, busy_a}, {e.led_a, e.busy_a});
            check(e.tag, e.cyc, "dut_r", {led_r, busy_r}, {e.led_r, e.busy_r});
            check(e.tag, e.cyc, "dut_i", {led_i, busy_i}, {e.led_i, e.busy_i});
         end
      end
   end

   task automatic run_por();
      stim_t s; exp_t e;
      for (int c = 0; c < 6; c++) begin
         s = idle_stim(); e = idle_exp("por", c);
         s.rst_n = !w(c, 0, 2);
         apply(s, e);
      end
   endtask

   task automatic run_single();
      stim_t s; exp_t e;
      for (int c = 0; c < 16; c++) begin
         s = idle_stim(); e = idle_exp("single", c);
         s.trig_a[0] = (c == 0);
         e.led_a[0]  = w(c, 3, 8);
         e.busy_a[0] = w(c, 3, 11);
         apply(s, e);
      end
   endtask

   task automatic run_hold();
      stim_t s; exp_t e;
      for (int c = 0; c < 30; c++) begin
         s = idle_stim(); e = idle_exp("hold", c);
         s.trig_a[1] = (c == 0);
         s.hold_a[1] = w(c, 0, 18);
         e.led_a[1]  = w(c, 3, 21);
         e.busy_a[1] = w(c, 3, 24);
         apply(s, e);
      end
   endtask

   // ch2: trigger mid-gap sets pend, third trigger lands in FLASH; ch3: trigger at gap expiry.
   task automatic run_pend();
      stim_t s; exp_t e;
      for (int c = 0; c < 30; c++) begin
         s = idle_stim(); e = idle_exp("pend", c);
         s.trig_a[2] = (c == 0) || (c == 8) || (c == 12);
         s.trig_a[3] = (c == 0) || (c == 9);
         e.led_a[2]  = w(c, 3, 8) || w(c, 12, 17);
         e.busy_a[2] = w(c, 3, 20);
         e.led_a[3]  = w(c, 3, 8) || w(c, 12, 17);
         e.busy_a[3] = w(c, 3, 20);
         apply(s, e);
      end
   endtask

   // Trigger present only in the last GAP cycle: goes through IDLE, so 4 dark clocks.
   task automatic run_gap_late();
      stim_t s; exp_t e;
      for (int c = 0; c < 28; c++) begin
         s = idle_stim(); e = idle_exp("gap_late", c);
         s.trig_a[2] = (c == 0) || (c == 10);
         e.led_a[2]  = w(c, 3, 8) || w(c, 13, 18);
         e.busy_a[2] = w(c, 3, 11) || w(c, 13, 21);
         apply(s, e);
      end
   endtask

   task automatic run_retrig();
      stim_t s; exp_t e;
      for (int c = 0; c < 20; c++) begin
         s = idle_stim(); e = idle_exp("retrig", c);
         s.trig_r[0] = (c == 0) || (c == 3);
         s.trig_a[0] = (c == 0) || (c == 3);
         e.led_r[0]  = w(c, 3, 11);
         e.busy_r[0] = w(c, 3, 14);
         e.led_a[0]  = w(c, 3, 8);
         e.busy_a[0] = w(c, 3, 11);
         apply(s, e);
      end
   endtask

   task automatic run_inv();
      stim_t s; exp_t e;
      for (int c = 0; c < 16; c++) begin
         s = idle_stim(); e = idle_exp("inv", c);
         s.trig_i = (c == 0) ? 4'hF : 4'h0;
         e.led_i  = w(c, 3, 8) ? 4'h0 : 4'hF;
         e.busy_i = w(c, 3, 11) ? 4'hF : 4'h0;
         apply(s, e);
      end
   endtask

   // Reset asserted between edges mid-FLASH; ch1 trigger held across reset release.
   task automatic run_reset();
      stim_t s; exp_t e;
      for (int c = 0; c < 36; c++) begin
         s = idle_stim(); e = idle_exp("reset", c);
         s.rst_n     = !w(c, 5, 6);
         s.trig_a[0] = (c == 0) || (c == 20);
         s.trig_a[1] = w(c, 5, 7);
         e.led_a[0]  = w(c, 3, 4) || w(c, 23, 28);
         e.busy_a[0] = w(c, 3, 4) || w(c, 23, 31);
         e.led_a[1]  = w(c, 10, 15);
         e.busy_a[1] = w(c, 10, 18);
         apply(s, e);
      end
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
      $fatal(1);
   end

   initial begin : stimulus
      run_por();
      run_single();
      run_hold();
      run_pend();
      run_gap_late();
      run_retrig();
      run_inv();
      run_reset();
      for (int k = 0; (k < 4) && (sb.size() > 0); k++) @(negedge clk);
      #1;
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
